// File: rtl/adder_stream_ctrl.sv
// adder_stream_ctrl: sequences one operand pair at a time through an external
// 6-bit adder. It registers the operands, waits SETTLE extra cycles for the
// adder to settle, captures the 7-bit sum and holds it until downstream
// accepts it. done_cnt counts completed output handshakes, modulo 256.
module adder_stream_ctrl #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [5:0] in_x,
  input  logic [5:0] in_y,
  output logic [5:0] add_x,
  output logic [5:0] add_y,
  input  logic [6:0] add_s,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [6:0] out_sum,
  output logic       out_carry,
  output logic [7:0] done_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  // Wait-counter load value; SETTLE is limited to 0..15.
  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [5:0] add_x_q, add_x_d;
  logic [5:0] add_y_q, add_y_d;
  logic [6:0] sum_q, sum_d;
  logic [7:0] done_q, done_d;

  // Next-state logic: accept in IDLE, count down in SETTLE, wait for
  // downstream in HOLD. Nothing bypasses IDLE between operations.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    add_x_d = add_x_q;
    add_y_d = add_y_q;
    sum_d   = sum_q;
    done_d  = done_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          add_x_d = in_x;
          add_y_d = in_y;
          cnt_d   = SETTLE_CNT;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // The adder result is taken verbatim, carry-out included.
          sum_d   = add_s;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          done_d  = done_q + 8'd1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any pending operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      add_x_q <= 6'd0;
      add_y_q <= 6'd0;
      sum_q   <= 7'd0;
      done_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      add_x_q <= add_x_d;
      add_y_q <= add_y_d;
      sum_q   <= sum_d;
      done_q  <= done_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_HOLD);
  assign add_x     = add_x_q;
  assign add_y     = add_y_q;
  assign out_sum   = sum_q;
  assign out_carry = sum_q[6];
  assign done_cnt  = done_q;

endmodule

// File: tb/tb_adder_stream_ctrl.sv
// Bench for adder_stream_ctrl: three instances (SETTLE = 0, 1, 3) each with
// its own external adder, a timestamp-based reference model, a per-cycle
// compare process and directed literal checks.
module tb_adder_stream_ctrl;

  logic       clk = 1'b0;
  logic       rst       [3];
  logic       in_valid  [3];
  logic       in_ready  [3];
  logic [5:0] in_x      [3];
  logic [5:0] in_y      [3];
  logic [5:0] add_x     [3];
  logic [5:0] add_y     [3];
  logic [6:0] add_s     [3];
  logic       out_valid [3];
  logic       out_ready [3];
  logic [6:0] out_sum   [3];
  logic       out_carry [3];
  logic [7:0] done_cnt  [3];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit stim_done = 1'b0;

  // Reference model state per lane
  logic       m_busy [3];
  logic       m_vld  [3];
  int         m_t0   [3];
  logic [5:0] m_x    [3];
  logic [5:0] m_y    [3];
  logic [6:0] m_sum  [3];
  logic [7:0] m_done [3];

  function automatic int settle_of(input int l);
    return (l == 0) ? 0 : ((l == 1) ? 1 : 3);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_lane
    localparam int S = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
    adder_stream_ctrl #(.SETTLE(S)) u_dut (
      .clk       (clk),
      .rst       (rst[g]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_x      (in_x[g]),
      .in_y      (in_y[g]),
      .add_x     (add_x[g]),
      .add_y     (add_y[g]),
      .add_s     (add_s[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_sum   (out_sum[g]),
      .out_carry (out_carry[g]),
      .done_cnt  (done_cnt[g])
    );
    // External 6-bit adder with carry-out in bit 6
    assign add_s[g] = {1'b0, add_x[g]} + {1'b0, add_y[g]};
  end

  always #5 clk = ~clk;

  // Model: an accepted pair at edge t0 produces its sum at edge t0+1+S,
  // which stays valid until downstream takes it.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int l = 0; l < 3; l++) begin
      if (rst[l]) begin
        m_busy[l] <= 1'b0;
        m_vld[l]  <= 1'b0;
        m_x[l]    <= 6'd0;
        m_y[l]    <= 6'd0;
        m_sum[l]  <= 7'd0;
        m_done[l] <= 8'd0;
      end else if (!m_busy[l]) begin
        if (in_valid[l]) begin
          m_busy[l] <= 1'b1;
          m_t0[l]   <= cyc;
          m_x[l]    <= in_x[l];
          m_y[l]    <= in_y[l];
        end
      end else if (!m_vld[l]) begin
        if (cyc == m_t0[l] + 1 + settle_of(l)) begin
          m_vld[l] <= 1'b1;
          m_sum[l] <= {1'b0, m_x[l]} + {1'b0, m_y[l]};
        end
      end else if (out_ready[l]) begin
        m_busy[l] <= 1'b0;
        m_vld[l]  <= 1'b0;
        m_done[l] <= m_done[l] + 8'd1;
      end
    end
  end

  task automatic check(input string nm, input int l, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s lane%0d: got %0d expected %0d (t=%0t)", nm, l, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm, input int l);
    tests++;
    fails++;
    $display("FAIL %s lane%0d: timed out waiting (t=%0t)", nm, l, $time);
  endtask

  task automatic compare_all();
    for (int l = 0; l < 3; l++) begin
      check("in_ready",  l, in_ready[l],  !m_busy[l]);
      check("out_valid", l, out_valid[l], m_vld[l]);
      check("add_x",     l, add_x[l],     m_x[l]);
      check("add_y",     l, add_y[l],     m_y[l]);
      check("out_sum",   l, out_sum[l],   m_sum[l]);
      check("out_carry", l, out_carry[l], m_sum[l][6]);
      check("done_cnt",  l, done_cnt[l],  m_done[l]);
    end
  endtask

  // what = 0: wait for in_ready, what = 1: wait for out_valid
  task automatic wait_for(input int l, input int what, input string nm);
    int n = 0;
    while (!((what == 0) ? in_ready[l] : out_valid[l]) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 40) timeout(nm, l);
  endtask

  // Issues one pair; returns 1ns after the accepting edge.
  task automatic do_op(input int l, input logic [5:0] x, input logic [5:0] y);
    wait_for(l, 0, "wait_in_ready");
    in_valid[l] = 1'b1;
    in_x[l] = x;
    in_y[l] = y;
    @(posedge clk); #1;
    in_valid[l] = 1'b0;
  endtask

  task automatic rand_phase(input int l, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rst[l]       = ($urandom_range(0, 49) == 0);
      in_valid[l]  = $urandom_range(0, 1) == 1;
      out_ready[l] = $urandom_range(0, 3) != 0;
      in_x[l]      = 6'($urandom);
      in_y[l]      = 6'($urandom);
    end
    @(posedge clk); #1;
    rst[l] = 1'b0;
    in_valid[l] = 1'b0;
  endtask

  // Continuous stream with out_ready high: results every 3+SETTLE cycles.
  task automatic stream_phase(input int l, input int n);
    int last = -1;
    rst[l] = 1'b0;
    out_ready[l] = 1'b1;
    in_valid[l] = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      in_x[l] = 6'($urandom);
      in_y[l] = 6'($urandom);
      if (out_valid[l]) begin
        if (last >= 0) check("interval", l, cyc - last, 3 + settle_of(l));
        last = cyc;
      end
    end
    in_valid[l] = 1'b0;
    if (last < 0) timeout("stream_result", l);
  endtask

  task automatic directed_lane1();
    // Reset state
    check("rst_in_ready",  1, in_ready[1],  1);
    check("rst_out_valid", 1, out_valid[1], 0);
    check("rst_done",      1, done_cnt[1],  0);
    check("rst_add_x",     1, add_x[1],     0);
    // 5 + 3 with SETTLE=1: valid appears after E0+2
    out_ready[1] = 1'b1;
    do_op(1, 6'd5, 6'd3);
    check("vld_e0", 1, out_valid[1], 0);
    @(posedge clk); #1;
    check("vld_e1", 1, out_valid[1], 0);
    @(posedge clk); #1;
    check("vld_e2",    1, out_valid[1], 1);
    check("sum_5_3",   1, out_sum[1],   8);
    check("carry_5_3", 1, out_carry[1], 0);
    check("model_5_3", 1, m_sum[1],     8);
    @(posedge clk); #1;
    check("done_1",    1, done_cnt[1], 1);
    check("ready_ret", 1, in_ready[1], 1);
    // Largest and smallest operands
    do_op(1, 6'd63, 6'd63);
    wait_for(1, 1, "wait_out_valid");
    check("sum_63_63",   1, out_sum[1],   126);
    check("carry_63_63", 1, out_carry[1], 1);
    @(posedge clk); #1;
    do_op(1, 6'd0, 6'd0);
    wait_for(1, 1, "wait_out_valid");
    check("sum_0_0",   1, out_sum[1],   0);
    check("carry_0_0", 1, out_carry[1], 0);
    @(posedge clk); #1;
    check("done_3", 1, done_cnt[1], 3);
    // Backpressure: result held, new pair waits for the handshake
    out_ready[1] = 1'b0;
    do_op(1, 6'd10, 6'd20);
    wait_for(1, 1, "wait_out_valid");
    in_valid[1] = 1'b1;
    in_x[1] = 6'd1;
    in_y[1] = 6'd2;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_sum",   1, out_sum[1],   30);
      check("hold_ready", 1, in_ready[1],  0);
      check("hold_add_x", 1, add_x[1],     10);
    end
    out_ready[1] = 1'b1;
    @(posedge clk); #1;
    check("hs_ready",  1, in_ready[1],  1);
    check("hs_add_x",  1, add_x[1],     10);
    check("hs_vld",    1, out_valid[1], 0);
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    check("acc_add_x", 1, add_x[1],    1);
    check("acc_add_y", 1, add_y[1],    2);
    check("acc_ready", 1, in_ready[1], 0);
    wait_for(1, 1, "wait_out_valid");
    check("sum_1_2", 1, out_sum[1], 3);
    @(posedge clk); #1;
    check("done_5", 1, done_cnt[1], 5);
    // Reset during SETTLE
    do_op(1, 6'd7, 6'd9);
    rst[1] = 1'b1;
    @(posedge clk); #1;
    rst[1] = 1'b0;
    check("rs_vld",   1, out_valid[1], 0);
    check("rs_add_x", 1, add_x[1],     0);
    check("rs_add_y", 1, add_y[1],     0);
    check("rs_done",  1, done_cnt[1],  0);
    check("rs_ready", 1, in_ready[1],  1);
    // Reset during HOLD
    out_ready[1] = 1'b0;
    do_op(1, 6'd11, 6'd12);
    wait_for(1, 1, "wait_out_valid");
    rst[1] = 1'b1;
    @(posedge clk); #1;
    rst[1] = 1'b0;
    out_ready[1] = 1'b1;
    check("rh_vld",   1, out_valid[1], 0);
    check("rh_add_x", 1, add_x[1],     0);
    check("rh_sum",   1, out_sum[1],   0);
    check("rh_ready", 1, in_ready[1],  1);
    @(posedge clk); #1;
    check("rh_done",  1, done_cnt[1],  0);
  endtask

  task automatic wrap_lane0();
    rst[0] = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    out_ready[0] = 1'b1;
    for (int k = 0; k < 256; k++) begin
      do_op(0, 6'($urandom), 6'($urandom));
      wait_for(0, 1, "wait_out_valid");
      @(posedge clk); #1;
      if (k == 254) check("done_255", 0, done_cnt[0], 255);
    end
    check("done_wrap", 0, done_cnt[0], 0);
  endtask

  initial begin
    for (int l = 0; l < 3; l++) begin
      rst[l] = 1'b1;
      in_valid[l] = 1'b0;
      out_ready[l] = 1'b0;
      in_x[l] = 6'd0;
      in_y[l] = 6'd0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int l = 0; l < 3; l++) rst[l] = 1'b0;
    fork
      begin
        while (!stim_done) begin
          @(negedge clk);
          compare_all();
        end
      end
      begin
        fork
          begin
            rand_phase(0, 200);
            stream_phase(0, 40);
            wrap_lane0();
          end
          begin
            directed_lane1();
            rand_phase(1, 200);
            stream_phase(1, 40);
          end
          begin
            rand_phase(2, 200);
            stream_phase(2, 60);
          end
        join
        repeat (3) @(posedge clk);
        stim_done = 1'b1;
      end
    join
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/adder_stream_ctrl.md
ADDER_STREAM_CTRL -- requirements
Module: adder_stream_ctrl

Interface
REQ-001 SHALL have parameter SETTLE, default 1, giving extra wait cycles (0..15) between driving operands and sampling the sum.
REQ-002 SHALL have one clock and a synchronous, active-high reset, named as in the port list below.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  upstream operand pair valid.
REQ-006 in_ready  output  1  block can accept an operand pair.
REQ-007 in_x  input  6  operand x.
REQ-008 in_y  input  6  operand y.
REQ-009 add_x  output  6  registered operand x, driven to the 6-bit adder's x.
REQ-010 add_y  output  6  registered operand y, driven to the 6-bit adder's y.
REQ-011 add_s  input  7  adder sum, carry-out in bit 6.
REQ-012 out_valid  output  1  result valid downstream.
REQ-013 out_ready  input  1  downstream accepts result.
REQ-014 out_sum  output  7  captured sum.
REQ-015 out_carry  output  1  equals out_sum[6].
REQ-016 done_cnt  output  8  count of completed output handshakes.

Function
REQ-017 SHALL implement FSM states IDLE, SETTLE, HOLD; the reset state is IDLE.
REQ-018 SHALL assert in_ready only in IDLE; in_valid in other states is ignored.
REQ-019 On an input handshake (in_valid & in_ready) at edge E0, the block SHALL register in_x/in_y into add_x/add_y, load the wait counter with SETTLE, and enter SETTLE.
REQ-020 In SETTLE, while the counter is nonzero, the block SHALL decrement it each cycle; at the edge where it is zero, it SHALL capture add_s into out_sum and enter HOLD.
REQ-021 out_valid SHALL be high exactly in HOLD, first high after edge E0+1+SETTLE.
REQ-022 In HOLD with out_ready low, out_sum and out_carry SHALL be held stable.
REQ-023 On an output handshake (out_valid & out_ready), the block SHALL return to IDLE and increment done_cnt mod 256 (255 -> 0).
REQ-024 There SHALL be no IDLE bypass; with out_ready tied high the throughput SHALL be one operation per 3+SETTLE cycles.
REQ-025 add_x/add_y SHALL hold the last accepted operands until the next input handshake.
REQ-026 Arithmetic SHALL be delegated entirely to the external adder; the block SHALL NOT modify add_s, which is captured verbatim into 7 bits.

Reset
REQ-027 While rst is high at a clock edge, the block SHALL set state=IDLE, wait counter=0, add_x=0, add_y=0, out_sum=0, out_valid=0, done_cnt=0; in_ready SHALL be 1 from the first cycle after reset deasserts.
REQ-028 A reset asserted in SETTLE or HOLD SHALL discard the pending operation, with no output handshake and no done_cnt increment.

Verification
REQ-029 SETTLE=1, in_x=5, in_y=3 with out_ready=1 -> out_valid rises after edge E0+2, out_sum=8, out_carry=0, done_cnt=1.
REQ-030 in_x=63, in_y=63 -> out_sum=126 (7'h7E), out_carry=1; in_x=0, in_y=0 -> out_sum=0.
REQ-031 out_ready low for 5 cycles in HOLD, in_valid held high with new operands -> out_sum stable, in_ready=0, new operands not accepted until the cycle after the output handshake.
REQ-032 SETTLE=0 and SETTLE=3 back-to-back streams with out_ready=1 -> one result every 3 and every 6 cycles respectively, results in input order.
REQ-033 rst pulsed during SETTLE, then during HOLD -> out_valid=0, add_x=add_y=0, done_cnt unchanged from its reset value 0, in_ready=1 next cycle.
REQ-034 256 completed operations -> done_cnt wraps to 0.
